// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the shared-adder arbiter slice.
//   OPW           operand width of the shared adder
//   SUMW          result width (operand width plus carry-out)
//   NREQ_DEFAULT  default number of requesters
//   rr_pick()     circular first-valid search from a pointer, one-hot result
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int OPW          = 16;
    localparam int SUMW         = 17;
    localparam int NREQ_DEFAULT = 4;
    localparam int RR_MAXREQ    = 8;

    // Returns a one-hot grant for the first set bit of valid, searching
    // ptr, ptr+1, ... and wrapping at n (not at 8), so pointers never
    // reach ids that do not exist when n is not a power of two.
    function automatic logic [RR_MAXREQ-1:0] rr_pick(
        input logic [RR_MAXREQ-1:0] valid,
        input logic [2:0]           ptr,
        input int                   n
    );
        logic [RR_MAXREQ-1:0] grant;
        int                   idx;
        grant = '0;
        for (int k = 0; k < RR_MAXREQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && grant == '0 && valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/recursive_adder.sv
// -----------------------------------------------------------------------------
// RecursiveAdder
// 16-bit Kogge-Stone parallel-prefix adder, purely combinational.
//   a, b  unsigned operands
//   sum   a + b with the carry-out in the top bit
// -----------------------------------------------------------------------------
module RecursiveAdder
    import adder_pkg::*;
(
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    output logic [SUMW-1:0] sum
);

    logic [OPW-1:0] half;
    logic [OPW-1:0] gen;
    logic [OPW-1:0] prop;
    logic [OPW-1:0] gen_n;
    logic [OPW-1:0] prop_n;

    always_comb begin
        half = a ^ b;
        gen  = a & b;
        prop = half;
        // Prefix levels at spans 1, 2, 4, 8: afterwards gen[i] is the carry
        // out of bit i (no carry-in).
        for (int d = 1; d < OPW; d = d * 2) begin
            gen_n  = gen;
            prop_n = prop;
            for (int i = d; i < OPW; i++) begin
                gen_n[i]  = gen[i] | (prop[i] & gen[i-d]);
                prop_n[i] = prop[i] & prop[i-d];
            end
            gen  = gen_n;
            prop = prop_n;
        end

        sum[0] = half[0];
        for (int i = 1; i < OPW; i++) begin
            sum[i] = half[i] ^ gen[i-1];
        end
        sum[OPW] = gen[OPW-1];
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter owning the priority pointer.
//   clk, reset  clock and asynchronous active-high reset
//   valid       per-requester request
//   enable      grants are issued only when high
//   advance     a grant was taken this cycle; pointer moves past the winner
//   grant       one-hot (or zero) grant, combinational
//   grant_idx   binary index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import adder_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] valid,
    input  logic            enable,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       ptr_d;
    logic [RR_MAXREQ-1:0] pick_all;
    logic                 pick_unused;

    always_comb begin
        pick_all = rr_pick(RR_MAXREQ'(valid), 3'(ptr_q), NREQ);
        grant    = enable ? pick_all[NREQ-1:0] : '0;

        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDW'(i);
            end
        end

        // Wrap explicitly at NREQ so non-power-of-two counts never point
        // at a nonexistent requester.
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Bits above NREQ are always zero; folded here so they are consumed.
    assign pick_unused = ^pick_all;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
// Shares one 16-bit prefix adder among NREQ requesters with round-robin
// arbitration and a single registered, backpressured response channel.
//   clk, reset          clock and asynchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        packed operands, requester i at [16i+15:16i]
//   rsp_valid/ready     response handshake
//   rsp_sum, rsp_id     17-bit sum and the id of the requester it belongs to
//   op_count            accepted operations, wraps modulo 2^16
// -----------------------------------------------------------------------------
module adder_share_arbiter
    import adder_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [16:0]       rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       op_count
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            slot_free;
    logic            accept;
    logic [OPW-1:0]  op_a;
    logic [OPW-1:0]  op_b;
    logic [SUMW-1:0] sum_full;
    logic [OPW-1:0]  masked_a [NREQ];
    logic [OPW-1:0]  masked_b [NREQ];

    logic            rsp_valid_q, rsp_valid_d;
    logic [SUMW-1:0] rsp_sum_q,   rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [15:0]     op_count_q,  op_count_d;

    // The result register can take a new value when empty or being drained.
    // Reset also suppresses grants so req_ready reads zero while it is held.
    assign slot_free = !rsp_valid_q || rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (req_valid),
        .enable    (slot_free && !reset),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A grant is only issued to a valid requester, so any grant is an accept.
    assign accept    = |grant;
    assign req_ready = grant;

    // One-hot AND-OR operand mux.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign masked_a[gi] = req_a[OPW*gi +: OPW] & {OPW{grant[gi]}};
            assign masked_b[gi] = req_b[OPW*gi +: OPW] & {OPW{grant[gi]}};
        end
    endgenerate

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a = op_a | masked_a[i];
            op_b = op_b | masked_b[i];
        end
    end

    RecursiveAdder u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (sum_full)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        op_count_d  = op_count_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = sum_full;
            rsp_id_d    = grant_idx;
            op_count_d  = op_count_q + 16'd1;
        end else if (rsp_ready) begin
            // Drain only; sum and id keep their last values.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
// Directed and randomized checks of adder_share_arbiter (NREQ=4) against a
// transaction-level reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [16:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic [15:0] op_count;

    logic [15:0] a_arr [NREQ];
    logic [15:0] b_arr [NREQ];

    int checks = 0;
    int errors = 0;

    // Reference model: the response slot, its owner, the next-priority id
    // and the accepted-operation count.
    logic        m_valid;
    logic [16:0] m_sum;
    int          m_id;
    int          m_ptr;
    int          m_count;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = a_arr[i];
            req_b[16*i +: 16] = b_arr[i];
        end
    end

    adder_share_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    // Requester protocol monitor: a pending request may not drop its valid.
    logic [3:0] pend_prev = 4'b0000;
    always @(posedge clk) begin
        if (reset) begin
            pend_prev = 4'b0000;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend_prev[i] && !req_valid[i]) begin
                    errors++;
                    $display("FAIL protocol: req %0d valid=%b, required held until accepted", i, req_valid[i]);
                end
            end
            pend_prev = req_valid & ~req_ready;
        end
    end

    function automatic logic [16:0] exp_sum(input int i);
        return {1'b0, a_arr[i]} + {1'b0, b_arr[i]};
    endfunction

    function automatic logic [3:0] model_grant();
        int i;
        if (m_valid && !rsp_ready) return 4'b0000;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = 0;
        m_ptr   = 0;
        m_count = 0;
    endtask

    task automatic model_edge(input logic [3:0] g);
        int i;
        i = 0;
        if (g != 4'b0000) begin
            for (int k = 0; k < NREQ; k++) if (g[k]) i = k;
            m_sum   = 17'(int'(a_arr[i]) + int'(b_arr[i]));
            m_id    = i;
            m_valid = 1'b1;
            m_ptr   = (i + 1) % NREQ;
            m_count = (m_count + 1) % 65536;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Inputs are set at posedge+1; req_ready is sampled at posedge+2, the
    // edge is taken, and the task returns at the following posedge+1.
    task automatic tick(output logic [3:0] exp_g, output logic [3:0] got_g);
        #1;
        got_g = req_ready;
        exp_g = model_grant();
        @(posedge clk);
        model_edge(exp_g);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 16'($urandom);
            b_arr[i] = 16'($urandom);
        end
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_sum !== 17'h0) begin errors++; $display("FAIL reset_rsp_sum: got %h expected 00000", rsp_sum); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count: got %h expected 0000", op_count); end
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        req_valid = 4'b0000;
        reset     = 1'b0;
        model_reset();
    endtask

    task automatic test_single_op();
        logic [3:0] e, g;
        a_arr[0]  = 16'h1234;
        b_arr[0]  = 16'h0001;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        tick(e, g);
        req_valid = 4'b0000;
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_req_ready: got %b expected 0001", g); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_sum !== 17'h01235) begin errors++; $display("FAIL single_rsp_sum: got %h expected 01235", rsp_sum); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_op_count: got %0d expected 1", op_count); end
        tick(e, g);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_sum !== 17'h01235) begin errors++; $display("FAIL drain_sum_held: got %h expected 01235", rsp_sum); end
    endtask

    task automatic test_carry();
        logic [3:0] e, g;
        a_arr[2]  = 16'hFFFF;
        b_arr[2]  = 16'hFFFF;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        tick(e, g);
        req_valid = 4'b0000;
        checks++; if (rsp_sum !== 17'h1FFFE) begin errors++; $display("FAIL carry_ffff_sum: got %h expected 1fffe", rsp_sum); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL carry_ffff_id: got %0d expected 2", rsp_id); end
        a_arr[2]  = 16'h8000;
        b_arr[2]  = 16'h8000;
        req_valid = 4'b0100;
        tick(e, g);
        req_valid = 4'b0000;
        checks++; if (rsp_sum !== 17'h10000) begin errors++; $display("FAIL carry_8000_sum: got %h expected 10000", rsp_sum); end
        checks++; if (op_count !== 16'(m_count)) begin errors++; $display("FAIL carry_op_count: got %0d expected %0d", op_count, m_count); end
    endtask

    task automatic test_round_robin();
        logic [3:0] e, g;
        int rr_ids [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 16'($urandom);
            b_arr[i] = 16'($urandom);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(e, g);
            checks++; if (g !== e) begin errors++; $display("FAIL rr_req_ready[%0d]: got %b expected %b", k, g, e); end
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b expected 1", k, rsp_valid); end
            checks++; if (rsp_id !== 2'(rr_ids[k])) begin errors++; $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", k, rsp_id, rr_ids[k]); end
            checks++; if (rsp_sum !== exp_sum(rr_ids[k])) begin errors++; $display("FAIL rr_rsp_sum[%0d]: got %h expected %h", k, rsp_sum, exp_sum(rr_ids[k])); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  e, g;
        logic [16:0] held;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 16'($urandom);
            b_arr[i] = 16'($urandom);
        end
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        tick(e, g);
        held = exp_sum(1);
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_first_id: got %0d expected 1", rsp_id); end
        req_valid = 4'b1001;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(e, g);
            checks++; if (g !== 4'b0000) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0000", k, g); end
            checks++; if (rsp_sum !== held) begin errors++; $display("FAIL bp_sum_held[%0d]: got %h expected %h", k, rsp_sum, held); end
            checks++; if (rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_id_held[%0d]: got id %0d valid %b expected id 1 valid 1", k, rsp_id, rsp_valid); end
        end
        rsp_ready = 1'b1;
        tick(e, g);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL bp_release_grant: got %b expected 1000", g); end
        checks++; if (rsp_id !== 2'd3 || rsp_sum !== exp_sum(3)) begin errors++; $display("FAIL bp_release_rsp: got id %0d sum %h expected id 3 sum %h", rsp_id, rsp_sum, exp_sum(3)); end
        req_valid = 4'b0001;
        tick(e, g);
        req_valid = 4'b0000;
        checks++; if (rsp_id !== 2'd0 || rsp_sum !== exp_sum(0)) begin errors++; $display("FAIL bp_followup_rsp: got id %0d sum %h expected id 0 sum %h", rsp_id, rsp_sum, exp_sum(0)); end
    endtask

    task automatic test_random();
        logic [3:0] e, g;
        int         wait_cnt [NREQ];
        do_reset();
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    a_arr[i]     = 16'($urandom);
                    b_arr[i]     = 16'($urandom);
                    req_valid[i] = 1'b1;
                    wait_cnt[i]  = 0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick(e, g);
            checks++; if (g !== e) begin errors++; $display("FAIL rand_req_ready[%0d]: got %b expected %b", n, g, e); end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && g != 4'b0000 && !g[i]) wait_cnt[i]++;
                if (g[i]) begin
                    checks++; if (wait_cnt[i] > NREQ - 1) begin errors++; $display("FAIL rand_fairness[%0d]: req %0d waited %0d accepts, required <= %0d", n, i, wait_cnt[i], NREQ - 1); end
                end
            end
            req_valid = req_valid & ~g;
            checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", n, rsp_valid, m_valid); end
            if (m_valid) begin
                checks++; if (rsp_sum !== m_sum || rsp_id !== 2'(m_id)) begin errors++; $display("FAIL rand_rsp[%0d]: got id %0d sum %h expected id %0d sum %h", n, rsp_id, rsp_sum, m_id, m_sum); end
            end
            checks++; if (op_count !== 16'(m_count)) begin errors++; $display("FAIL rand_op_count[%0d]: got %0d expected %0d", n, op_count, m_count); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [3:0] e, g;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 16'($urandom);
            b_arr[i] = 16'($urandom);
        end
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        tick(e, g);
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        tick(e, g);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL mid_pending: got valid %b id %0d expected valid 1 id 2", rsp_valid, rsp_id); end
        req_valid = 4'b1010;
        reset     = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 17'h0 || rsp_id !== 2'd0) begin errors++; $display("FAIL mid_async_rsp: got valid %b sum %h id %0d expected 0 00000 0", rsp_valid, rsp_sum, rsp_id); end
        checks++; if (op_count !== 16'h0 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_async_state: got count %0d ready %b expected 0 0000", op_count, req_ready); end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        model_reset();
        tick(e, g);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL mid_first_grant: got %b expected 0010", g); end
        req_valid = req_valid & ~g;
        checks++; if (rsp_id !== 2'd1 || rsp_sum !== exp_sum(1)) begin errors++; $display("FAIL mid_first_rsp: got id %0d sum %h expected id 1 sum %h", rsp_id, rsp_sum, exp_sum(1)); end
        tick(e, g);
        req_valid = req_valid & ~g;
        checks++; if (rsp_id !== 2'd3 || rsp_sum !== exp_sum(3)) begin errors++; $display("FAIL mid_second_rsp: got id %0d sum %h expected id 3 sum %h", rsp_id, rsp_sum, exp_sum(3)); end
        req_valid = 4'b0000;
    endtask

    task automatic test_counter_wrap();
        logic [3:0] e, g;
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (65535) tick(e, g);
        checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected ffff", op_count); end
        tick(e, g);
        checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", op_count); end
        tick(e, g);
        checks++; if (op_count !== 16'h0001) begin errors++; $display("FAIL wrap_one: got %h expected 0001", op_count); end
        do_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_op();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 16-bit parallel-prefix adder (RecursiveAdder, 17-bit sum including carry-out) among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one pair per cycle.
- The registered 17-bit sum returns on a single response channel, tagged with the requester id and subject to backpressure.
- Sits between the scalar issue units and the shared adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester id; must equal clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept. One-hot or zero; combinational grant.
- req_a  in  NREQ*16  operand A, requester i at bits [16i+15:16i].
- req_b  in  NREQ*16  operand B, same packing as req_a.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  17  registered a+b, bit 16 = carry-out.
- rsp_id  out  IDW  index of the requester that produced rsp_sum.
- op_count  out  16  number of accepted operations, wraps modulo 2^16.

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_sum=0, rsp_id=0, op_count=0, round-robin pointer=0, req_ready=0.
- Slot free: free = !rsp_valid | rsp_ready. When free is 0, all req_ready are 0.
- Grant when free: req_ready[g]=1 for exactly one g. g is the first i with req_valid[i]=1, searching circularly from the pointer (ptr, ptr+1, …, ptr+NREQ-1 mod NREQ).
- No request valid: req_ready=0.
- req_ready depends only on req_valid, rsp_valid, rsp_ready and state. It never depends on operands.
- Accept (req_valid[g] & req_ready[g]) at edge N:
  - rsp_sum <= req_a[g] + req_b[g] through the shared adder;
  - rsp_id <= g; rsp_valid <= 1;
  - ptr <= (g+1) mod NREQ;
  - op_count <= op_count+1.
- Latency: a result is visible the cycle after acceptance. Throughput is 1 op/cycle while rsp_ready=1.
- Consume without new accept (rsp_valid & rsp_ready, no grant): rsp_valid <= 0. rsp_sum and rsp_id keep their old values.
- Simultaneous consume and accept: the new result replaces the old one in the same edge with no bubble.
- Backpressure (rsp_valid & !rsp_ready): rsp_sum, rsp_id and rsp_valid are held stable. No grant is issued and the pointer does not move.
- Requester rules:
  - Once req_valid[i] is raised, it and the operands stay stable until accepted.
  - Dropping valid early is a protocol violation; the bench flags it.
- Fairness: a continuously valid requester is accepted within NREQ accepts of any other requester.
- Arithmetic: the full 17-bit unsigned sum. 0xFFFF+0xFFFF = 0x1FFFE. No truncation or saturation.
- op_count wraps 0xFFFF -> 0x0000 silently.
- Reset mid-operation: a pending result is discarded and no response is emitted for it. Requesters must re-present.
- NREQ not a power of two: the pointer wraps at NREQ, not 2^IDW. Ids >= NREQ never appear on rsp_id.

Decomposition:
- Shared package adder_pkg:
  - OPW=16, SUMW=17;
  - function rr_pick(valid, ptr) returning the one-hot grant;
  - localparam for the default NREQ.
- Sub-module rr_arbiter (NREQ): inputs valid, enable, advance; outputs grant one-hot and grant index. It owns the pointer register.
- The top level holds:
  - the operand mux (one-hot AND-OR);
  - one RecursiveAdder instance;
  - the response register;
  - op_count.

Test Plan:
- Single op: after reset, req0 valid a=0x1234 b=0x0001, rsp_ready=1.
  - Cycle 0: req_ready=0001.
  - Cycle 1: rsp_valid=1, rsp_sum=0x01235, rsp_id=0, op_count=1.
- Carry-out: req2 a=0xFFFF b=0xFFFF -> rsp_sum=0x1FFFE, rsp_id=2. Then a=0x8000 b=0x8000 -> 0x10000.
- Round robin: all four valid continuously, rsp_ready=1.
  - Ids are 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
  - Each result equals its requester's a+b.
- Backpressure: result id1 pending, rsp_ready=0 for 3 cycles, req0 and req3 valid.
  - rsp_sum and rsp_id are held; req_ready=0000 throughout.
  - On the rsp_ready=1 cycle, req3 is granted and the next cycle shows id3.
- Reset mid-flight: async reset asserted while rsp_valid=1 and rsp_ready=0.
  - Outputs go to zero immediately, without waiting for a clock edge.
  - After release, the first grant goes to the lowest valid id starting from 0; the old result never appears.
- Counter wrap: force 65536 accepts -> op_count reads 0x0000, then 0x0001 after the next accept.
